instr_fetch_loader: RTL

- Front end of the processor, directly upstream of the program counter.
- At boot, receives a byte stream (program image) and writes it into the external synchronous instruction RAM while holding the core in reset.
- Then releases the core and fetches from the address given by the program counter, presenting opcode/operand words for the PC and ALU.
- Squashes the wrong-path word that follows a taken PC jump by substituting a NOP.

---
 rtl/instr_fetch_loader_if.sv | 37 +++
 rtl/instr_fetch_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/instr_fetch_loader_if.sv
// Bus bundle between the instruction fetch/loader and its neighbours:
// boot byte stream, instruction RAM port, PC input and instruction outputs.
interface instr_fetch_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                    load_valid;
    logic [7:0]              load_data;
    logic                    load_last;
    logic                    load_ready;
    logic                    boot_skip;
    logic                    core_reset;
    logic [DATA_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   imem_addr;
    logic                    imem_we;
    logic [2*DATA_WIDTH-1:0] imem_wdata;
    logic [2*DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0]   opcode;
    logic [DATA_WIDTH-1:0]   operand;
    logic                    instr_valid;
    logic                    load_error;
    logic [31:0]             instr_count;

    // Loader side
    modport master (
        input  load_valid, load_data, load_last, boot_skip, pc, imem_rdata,
        output load_ready, core_reset, imem_addr, imem_we, imem_wdata,
               opcode, operand, instr_valid, load_error, instr_count
    );

    // Environment side (byte source, RAM, PC/ALU)
    modport slave (
        output load_valid, load_data, load_last, boot_skip, pc, imem_rdata,
        input  load_ready, core_reset, imem_addr, imem_we, imem_wdata,
               opcode, operand, instr_valid, load_error, instr_count
    );
endinterface

// File: rtl/instr_fetch_loader.sv
// Boot loader and instruction fetch front end. Loads a big-endian byte image
// into the instruction RAM while holding the core in reset, releases the core,
// then fetches at the PC and squashes the wrong-path word after a redirect.
module instr_fetch_loader #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_loader_if.master  bus
);
    localparam int WORD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    // Extra MSB marks "RAM full": further bytes are dropped, never wrapped.
    logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic [23:0]             byte_buf_q, byte_buf_d;
    logic                    load_error_q, load_error_d;
    logic [31:0]             instr_count_q, instr_count_d;
    logic                    run_seen_q, run_seen_d;
    logic [DATA_WIDTH-1:0]   pc_prev_q, pc_prev_d;

    logic                    in_load, in_run, accept, ram_full, word_done;
    logic                    squash, issue, no_bytes_yet;
    logic [DATA_WIDTH-1:0]   pc_seq;
    logic [31:0]             asm_word;

    // Datapath decode: byte acceptance, word assembly with zero padding, squash
    always_comb begin
        in_load      = (state_q == S_LOAD);
        in_run       = (state_q == S_RUN) && !reset;
        accept       = in_load && bus.load_valid && !reset;
        ram_full     = word_cnt_q[ADDR_WIDTH];
        word_done    = accept && ((byte_cnt_q == 2'd3) || bus.load_last);
        no_bytes_yet = (byte_cnt_q == 2'd0) && (word_cnt_q == '0);
        pc_seq       = pc_prev_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        // First RUN cycle shows a stale read; a non-sequential PC means the
        // word being presented belongs to the path that was jumped over.
        squash       = !run_seen_q || (bus.pc != pc_seq);
        issue        = in_run && !squash;
        case (byte_cnt_q)
            2'd0:    asm_word = {bus.load_data, 24'h0};
            2'd1:    asm_word = {byte_buf_q[7:0], bus.load_data, 16'h0};
            2'd2:    asm_word = {byte_buf_q[15:0], bus.load_data, 8'h0};
            default: asm_word = {byte_buf_q, bus.load_data};
        endcase
    end

    assign bus.load_ready  = in_load || reset;
    assign bus.core_reset  = (state_q != S_RUN) || reset;
    assign bus.imem_we     = word_done && !ram_full;
    assign bus.imem_addr   = in_load ? word_cnt_q[ADDR_WIDTH-1:0] : bus.pc[ADDR_WIDTH-1:0];
    assign bus.imem_wdata  = WORD_W'(asm_word);
    assign bus.opcode      = issue ? bus.imem_rdata[WORD_W-1:DATA_WIDTH] : NOP_OPCODE;
    assign bus.operand     = issue ? bus.imem_rdata[DATA_WIDTH-1:0] : '0;
    assign bus.instr_valid = issue;
    assign bus.load_error  = load_error_q;
    assign bus.instr_count = instr_count_q;

    // Next-state logic for the LOAD -> RELEASE -> RUN sequence and counters
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        byte_buf_d    = byte_buf_q;
        load_error_d  = load_error_q;
        run_seen_d    = (state_q == S_RUN);
        pc_prev_d     = bus.pc;
        instr_count_d = issue ? instr_count_q + 32'd1 : instr_count_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    byte_buf_d = {byte_buf_q[15:0], bus.load_data};
                    byte_cnt_d = bus.load_last ? 2'd0 : byte_cnt_q + 2'd1;
                    if (word_done && !ram_full)
                        word_cnt_d = word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if (ram_full)
                        load_error_d = 1'b1;
                    if (bus.load_last)
                        state_d = S_RELEASE;
                end else if (bus.boot_skip && no_bytes_yet) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    // Control registers; reset returns to LOAD with counters and error cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            byte_cnt_q    <= 2'd0;
            word_cnt_q    <= '0;
            load_error_q  <= 1'b0;
            instr_count_q <= 32'd0;
            run_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            load_error_q  <= load_error_d;
            instr_count_q <= instr_count_d;
            run_seen_q    <= run_seen_d;
        end
    end

    // Data registers: partial-word bytes and the previous PC need no reset
    always_ff @(posedge clk) begin
        byte_buf_q <= byte_buf_d;
        pc_prev_q  <= pc_prev_d;
    end
endmodule
